// File: rtl/ccl_pkg.sv
// Shared types and default geometry for the CCL frame sequencer.
package ccl_pkg;

  localparam int unsigned IMG_WIDTH_DEF  = 10;
  localparam int unsigned IMG_HEIGHT_DEF = 10;
  localparam int unsigned H_BLANK_DEF    = 10;
  localparam int unsigned V_TAIL_DEF     = 900;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ACTIVE,
    ST_TAIL
  } seq_state_e;

  // Width helper that never returns zero, so 1-entry ranges still get a 1-bit vector.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ccl_seq_timer.sv
// Loadable down-counter; expired flags the final cycle of a loaded interval.
module ccl_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // A load of N therefore spans exactly N enabled cycles.
  assign expired = (count <= W'(1));

endmodule

// File: rtl/ccl_frame_sequencer.sv
// Streams a binary image from pixel memory to CCL as vsync/href/bit timing.
// Optional CCL_SEQ_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module ccl_frame_sequencer
  import ccl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned H_BLANK    = H_BLANK_DEF,
  parameter int unsigned V_TAIL     = V_TAIL_DEF,
  parameter int unsigned ADDR_W     = clog2_min1(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_data,
  output logic              per_img_vsync,
  output logic              per_img_href,
  output logic              per_img_bit
`ifdef CCL_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int unsigned COL_W = clog2_min1(IMG_WIDTH);
  localparam int unsigned ROW_W = clog2_min1(IMG_HEIGHT);
  localparam int unsigned TMR_W = clog2_min1(((H_BLANK > V_TAIL) ? H_BLANK : V_TAIL) + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  seq_state_e        state, state_n;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr;
  logic              tmr_load, tmr_en, tmr_expired;
  logic [TMR_W-1:0]  tmr_val;
  logic              line_end, frame_end;
  logic              vsync_q, href_q;

  assign line_end  = (col == COL_LAST);
  assign frame_end = line_end && (row == ROW_LAST);

  ccl_seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(H_BLANK);
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_n  = ST_BLANK;
          tmr_load = 1'b1;
        end
      end
      ST_BLANK: begin
        if (tmr_expired) state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (line_end) begin
          tmr_load = 1'b1;
          if (frame_end) begin
            state_n = ST_TAIL;
            tmr_val = TMR_W'(V_TAIL);
          end else begin
            state_n = ST_BLANK;
          end
        end
      end
      ST_TAIL: begin
        if (tmr_expired) begin
          state_n = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) begin
      state_n  = ST_IDLE;
      tmr_load = 1'b0;
      done     = 1'b0;
    end
  end

  assign tmr_en    = (state == ST_BLANK) || (state == ST_TAIL);
  assign busy      = (state != ST_IDLE);
  assign mem_rd_en = (state == ST_ACTIVE);

  // Running address replaces row*IMG_WIDTH+col; it holds on the last pixel so it never overruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      row     <= '0;
      col     <= '0;
      addr    <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      state   <= state_n;
      vsync_q <= ((state == ST_BLANK) || (state == ST_ACTIVE)) && !abort;
      href_q  <= (state == ST_ACTIVE) && !abort;
      if (state == ST_IDLE) begin
        row  <= '0;
        col  <= '0;
        addr <= '0;
      end else if (state == ST_ACTIVE) begin
        if (line_end) begin
          col <= '0;
          if (!frame_end) row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!frame_end) addr <= addr + 1'b1;
      end
    end
  end

  assign mem_rd_addr   = mem_rd_en ? addr : '0;
  assign per_img_vsync = vsync_q;
  assign per_img_href  = href_q;
  assign per_img_bit   = href_q & mem_rd_data;

`ifdef CCL_SEQ_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ccl_frame_sequencer.sv
// Directed bench for ccl_frame_sequencer: default 10x10 instance plus a 1x1 instance.
module tb_ccl_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, abort, start1, abort1;
  logic busy, done, mem_rd_en, mem_rd_data, per_img_vsync, per_img_href, per_img_bit;
  logic [6:0] mem_rd_addr;
  logic busy1, done1, mem_rd_en1, mem_rd_data1, per_img_vsync1, per_img_href1, per_img_bit1;
  logic [0:0] mem_rd_addr1;
`ifdef CCL_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt1;
`endif

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ccl_frame_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .per_img_vsync(per_img_vsync),
    .per_img_href(per_img_href), .per_img_bit(per_img_bit)
`ifdef CCL_SEQ_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  ccl_frame_sequencer #(
    .IMG_WIDTH(1), .IMG_HEIGHT(1), .H_BLANK(2), .V_TAIL(5), .ADDR_W(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1),
    .mem_rd_data(mem_rd_data1), .per_img_vsync(per_img_vsync1),
    .per_img_href(per_img_href1), .per_img_bit(per_img_bit1)
`ifdef CCL_SEQ_FRAME_CNT_EN
    , .frame_cnt(frame_cnt1)
`endif
  );

  // Checkerboard image; idle data is 1 so an ungated per_img_bit shows up.
  function automatic logic pat(input int i);
    return 1'(((i / 10) + (i % 10)) & 1);
  endfunction

  always @(posedge clk) begin
    mem_rd_data  <= mem_rd_en ? pat(int'(mem_rd_addr)) : 1'b1;
    mem_rd_data1 <= mem_rd_en1;
  end

  int m_vsr, m_vs_rise, m_vs_fall, m_gap, m_first_href, m_lines, m_line_err, m_gap_err;
  int m_nbits, m_bit_err, m_rd, m_addr_err, m_done, m_done_cyc, m_busy, m_hrun, m_hgap;
  logic vs_p, hr_p;

  task automatic clr_mon();
    m_vsr = 0; m_vs_rise = -1; m_vs_fall = 0; m_gap = -1; m_first_href = -1;
    m_lines = 0; m_line_err = 0; m_gap_err = 0; m_nbits = 0; m_bit_err = 0;
    m_rd = 0; m_addr_err = 0; m_done = 0; m_done_cyc = -1; m_busy = 0;
    m_hrun = 0; m_hgap = 0; vs_p = 1'b0; hr_p = 1'b0;
  endtask

  always @(negedge clk) begin
    if (per_img_vsync && !vs_p) begin
      m_vsr++;
      if (m_vsr == 1) m_vs_rise = cyc;
      m_gap = cyc - m_vs_fall;
    end
    if (!per_img_vsync && vs_p) m_vs_fall = cyc;
    if (per_img_href) begin
      if (!hr_p) begin
        if (m_first_href < 0) m_first_href = cyc;
        else if (m_hgap != 10) m_gap_err++;
      end
      if (per_img_bit !== pat(m_nbits % 100)) m_bit_err++;
      m_nbits++;
      m_hrun++;
    end else begin
      if (per_img_bit !== 1'b0) m_bit_err++;
      if (hr_p) begin
        m_lines++;
        if (m_hrun != 10) m_line_err++;
        m_hrun = 0;
        m_hgap = 0;
      end
      m_hgap++;
    end
    if (mem_rd_en) begin
      if (mem_rd_addr !== 7'(m_rd % 100)) m_addr_err++;
      m_rd++;
    end
    if (done) begin
      m_done++;
      m_done_cyc = cyc;
    end
    if (busy) m_busy++;
    vs_p = per_img_vsync;
    hr_p = per_img_href;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(output int s);
    start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_frame(input int s, input string t);
    chk({t, "_vs_rises"}, 32'(m_vsr), 1);
    chk({t, "_vs_rise"}, 32'(m_vs_rise), 32'(s + 2));
    chk({t, "_first_href"}, 32'(m_first_href), 32'(s + 12));
    chk({t, "_lines"}, 32'(m_lines), 10);
    chk({t, "_line_len_err"}, 32'(m_line_err), 0);
    chk({t, "_hblank_err"}, 32'(m_gap_err), 0);
    chk({t, "_nbits"}, 32'(m_nbits), 100);
    chk({t, "_bit_err"}, 32'(m_bit_err), 0);
    chk({t, "_reads"}, 32'(m_rd), 100);
    chk({t, "_addr_err"}, 32'(m_addr_err), 0);
    chk({t, "_ndone"}, 32'(m_done), 1);
    chk({t, "_done_cyc"}, 32'(m_done_cyc), 32'(s + 1100));
    chk({t, "_busy_cycles"}, 32'(m_busy), 1100);
  endtask

  logic [4:0] exp6 [1:9];

  initial begin
    int s, s2;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    clr_mon();
    #3;
    chk("rst_outputs", 32'({busy, done, mem_rd_en, per_img_vsync, per_img_href, per_img_bit}), 0);
    chk("rst_addr", 32'(mem_rd_addr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame
    clr_mon();
    start_frame(s);
    goto(s + 1150);
    check_frame(s, "f1");

    // Second start 50 cycles in is ignored
    clr_mon();
    start_frame(s);
    goto(s + 50);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    goto(s + 1200);
    check_frame(s, "restart");

    // Abort at row 3, col 4
    clr_mon();
    start_frame(s);
    goto(s + 75);
    chk("abort_pre_addr", 32'(mem_rd_addr), 34);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_outputs", 32'({busy, done, mem_rd_en, per_img_vsync, per_img_href}), 0);
    goto(s + 1200);
    chk("abort_ndone", 32'(m_done), 0);
    chk("abort_nbits", 32'(m_nbits), 34);
    chk("abort_reads", 32'(m_rd), 35);
    chk("abort_bit_err", 32'(m_bit_err), 0);
    clr_mon();
    start_frame(s);
    goto(s + 1150);
    check_frame(s, "post_abort");

    // Reset during ACTIVE
    clr_mon();
    start_frame(s);
    goto(s + 53);
    chk("mid_rst_pre_addr", 32'(mem_rd_addr), 22);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'({busy, done, mem_rd_en, per_img_vsync, per_img_href, per_img_bit}), 0);
    chk("mid_rst_addr", 32'(mem_rd_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clr_mon();
    repeat (100) @(posedge clk);
    #1;
    chk("post_rst_quiet", 32'(m_vsr + m_rd + m_busy + m_done), 0);

    // Back-to-back frames, second start on done cycle + 1
    clr_mon();
    start_frame(s);
    goto(s + 1100);
    chk("b2b_done_now", 32'(done), 1);
    goto(s + 1101);
    start_frame(s2);
    goto(s2 + 1150);
    chk("b2b_ndone", 32'(m_done), 2);
    chk("b2b_vs_rises", 32'(m_vsr), 2);
    chk("b2b_vs_gap", 32'(m_gap), 901);
    chk("b2b_done_cyc", 32'(m_done_cyc), 32'(s2 + 1100));
    chk("b2b_nbits", 32'(m_nbits), 200);
    chk("b2b_bit_err", 32'(m_bit_err), 0);
    chk("b2b_addr_err", 32'(m_addr_err), 0);
`ifdef CCL_SEQ_FRAME_CNT_EN
    chk("b2b_frame_cnt", 32'(frame_cnt), 2);
`endif

    // 1x1 image, H_BLANK=2, V_TAIL=5: {vsync, href, rd_en, done, busy}
    exp6[1] = 5'b00001; exp6[2] = 5'b10001; exp6[3] = 5'b10101;
    exp6[4] = 5'b11001; exp6[5] = 5'b00001; exp6[6] = 5'b00001;
    exp6[7] = 5'b00001; exp6[8] = 5'b00011; exp6[9] = 5'b00000;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("u1_k%0d", k),
          32'({per_img_vsync1, per_img_href1, mem_rd_en1, done1, busy1}), 32'(exp6[k]));
      if (k == 3) chk("u1_addr", 32'(mem_rd_addr1), 0);
      if (k == 4) chk("u1_bit", 32'(per_img_bit1), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccl_frame_sequencer.md
CCL_FRAME_SEQUENCER -- requirements
Module: ccl_frame_sequencer

Interface
REQ-001 Parameter IMG_WIDTH, default 10, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 10, lines per frame.
REQ-003 Parameter H_BLANK, default 10, href-low cycles before each line; minimum 2.
REQ-004 Parameter V_TAIL, default 900, vsync-low cycles after the last line so CCL can flush before done; minimum 1.
REQ-005 Parameter ADDR_W, default $clog2(IMG_WIDTH*IMG_HEIGHT), pixel memory address width.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle frame request.
REQ-009 abort  in  1  cancel current frame.
REQ-010 busy  out  1  frame in progress.
REQ-011 done  out  1  one-cycle frame-complete pulse.
REQ-012 mem_rd_en  out  1  pixel memory read strobe.
REQ-013 mem_rd_addr  out  ADDR_W  raster address row*IMG_WIDTH+col.
REQ-014 mem_rd_data  in  1  binary pixel, valid exactly 1 cycle after mem_rd_en.
REQ-015 per_img_vsync  out  1  frame valid to CCL.
REQ-016 per_img_href  out  1  line valid to CCL.
REQ-017 per_img_bit  out  1  pixel to CCL, qualified by per_img_href.

Function
REQ-018 FSM states: IDLE, BLANK, ACTIVE, TAIL; all transitions on rising clk.
REQ-019 IDLE: start=1 -> BLANK; row=0, col=0, blank timer loaded with H_BLANK.
REQ-020 BLANK: timer counts down; at expiry -> ACTIVE.
REQ-021 ACTIVE: mem_rd_en=1 each cycle, col increments; after IMG_WIDTH cycles -> BLANK if row<IMG_HEIGHT-1 (row increments), else TAIL.
REQ-022 TAIL: V_TAIL cycles, then -> IDLE with done=1 for exactly one cycle.
REQ-023 Internal vsync = state in {BLANK, ACTIVE}; internal href = state==ACTIVE.
REQ-024 per_img_vsync and per_img_href shall be the internal vsync/href delayed by 1 register, aligning with mem_rd_data.
REQ-025 per_img_bit shall equal mem_rd_data when per_img_href=1, else 0.
REQ-026 per_img_vsync rises 2 cycles after start is sampled.
REQ-027 The first per_img_href rises H_BLANK cycles after the per_img_vsync rise.
REQ-028 Each line produces exactly IMG_WIDTH contiguous href-high cycles; there are exactly H_BLANK href-low cycles between lines.
REQ-029 busy=1 from the cycle after start is sampled through the done cycle inclusive.
REQ-030 start while busy=1 shall be ignored and not queued.
REQ-031 abort=1 in any non-IDLE state -> IDLE next cycle; mem_rd_en=0; per_img_href and per_img_vsync low within 1 cycle; no done pulse.
REQ-032 Simultaneous start and abort in IDLE: abort wins, state remains IDLE.
REQ-033 Last read address shall be IMG_WIDTH*IMG_HEIGHT-1; no address beyond that is ever issued.

Reset
REQ-034 rst_n low, asynchronously: state=IDLE, counters=0, and all outputs (busy, done, mem_rd_en, mem_rd_addr, per_img_vsync, per_img_href, per_img_bit) = 0.
REQ-035 Reset asserted mid-frame abandons the frame; after release no output activity until a new start.

Configuration
REQ-036 CCL_SEQ_FRAME_CNT_EN defined: adds output frame_cnt [15:0], reset 0, incremented on each done, wrapping 0xFFFF -> 0x0000; aborted frames are not counted.
REQ-037 CCL_SEQ_FRAME_CNT_EN undefined: the frame_cnt port and its counter are absent; all other behaviour is identical.

Structure
REQ-038 Package ccl_pkg holds the FSM state enum typedef and the default IMG_WIDTH/IMG_HEIGHT/H_BLANK/V_TAIL constants.
REQ-039 Blank and tail timing uses one sub-module, ccl_seq_timer: a loadable down-counter with an expiry flag.

Verification
REQ-040 Defaults, memory checkerboard, one start -> vsync high for 10 lines of 10 href cycles, bit stream matches memory, done at the expected cycle.
REQ-041 start pulsed again 50 cycles into a frame -> output sequence identical to a single-start run, one done.
REQ-042 abort during row 3, col 4 -> href and vsync low next cycle, no done, busy=0; a later start produces a full correct frame.
REQ-043 rst_n low during ACTIVE -> all outputs 0 immediately; after release, quiet until start.
REQ-044 Back-to-back frames, start on the done cycle+1 -> vsync gap of V_TAIL+1 cycles; with CCL_SEQ_FRAME_CNT_EN, frame_cnt=2 after the second frame.
REQ-045 IMG_WIDTH=1, IMG_HEIGHT=1, H_BLANK=2 -> single 1-cycle href, address 0 only, done after V_TAIL.
